// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for an ALU.
// Reads {a,b,op} vectors and gold results from a synchronous ROM, one vector
// every three cycles (FETCH, APPLY, CHECK). It drives the ALU operand ports,
// compares the combinational ALU result with gold, and counts mismatching vectors.
// Optional feature macro: ALU_BIST_FAIL_LOG_EN adds a log of the first mismatch
// (o_fail_valid, o_fail_idx, o_fail_result).
module alu_bist #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  output logic [AW-1:0]           o_vec_addr,
  input  logic [2*WIDTH+OP_W-1:0] i_vec_data,
  input  logic [WIDTH-1:0]        i_gold_data,
  output logic [WIDTH-1:0]        o_alu_a,
  output logic [WIDTH-1:0]        o_alu_b,
  output logic [OP_W-1:0]         o_alu_op,
  input  logic [WIDTH-1:0]        i_alu_result,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
`ifdef ALU_BIST_FAIL_LOG_EN
  output logic                    o_fail_valid,
  output logic [AW-1:0]           o_fail_idx,
  output logic [WIDTH-1:0]        o_fail_result,
`endif
  output logic [CW-1:0]           o_err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    index;
  logic [WIDTH-1:0] gold_q;
  logic             start_run;
  logic             last_vec;
  logic             mismatch;

  // A start is honoured only when no run is in flight.
  assign start_run = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_vec  = (index == AW'(DEPTH - 1));
  assign mismatch  = (i_alu_result != gold_q);
  assign o_pass    = o_done && (o_err_count == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: three states per vector, then DONE after the last one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_FETCH;
      S_FETCH: state_d = S_APPLY;
      S_APPLY: state_d = S_CHECK;
      S_CHECK: state_d = last_vec ? S_DONE : S_FETCH;
      S_DONE:  if (i_start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping and datapath. The ROM address is loaded on entry to FETCH.
  // The ROM then returns data during APPLY, and the operands and gold are
  // latched as APPLY ends.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      index       <= '0;
      o_vec_addr  <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      gold_q      <= '0;
      o_err_count <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef ALU_BIST_FAIL_LOG_EN
      o_fail_valid  <= 1'b0;
      o_fail_idx    <= '0;
      o_fail_result <= '0;
`endif
    end else if (start_run) begin
      index       <= '0;
      o_vec_addr  <= '0;
      o_err_count <= '0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
`ifdef ALU_BIST_FAIL_LOG_EN
      o_fail_valid  <= 1'b0;
      o_fail_idx    <= '0;
      o_fail_result <= '0;
`endif
    end else begin
      case (state_q)
        S_APPLY: begin
          o_alu_a  <= i_vec_data[2*WIDTH+OP_W-1 -: WIDTH];
          o_alu_b  <= i_vec_data[WIDTH+OP_W-1 -: WIDTH];
          o_alu_op <= i_vec_data[OP_W-1:0];
          gold_q   <= i_gold_data;
        end
        S_CHECK: begin
          if (mismatch) begin
            o_err_count <= o_err_count + 1'b1;
`ifdef ALU_BIST_FAIL_LOG_EN
            if (!o_fail_valid) begin
              o_fail_valid  <= 1'b1;
              o_fail_idx    <= index;
              o_fail_result <= i_alu_result;
            end
`endif
          end
          if (last_vec) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            index      <= index + 1'b1;
            o_vec_addr <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist. It provides a behavioural ALU and a synchronous ROM,
// and it uses a scoreboard of expected run outcomes that a monitor consumes
// whenever o_done rises.
module tb_alu_bist;

  localparam int WIDTH = 32;
  localparam int OP_W  = 5;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic                    i_clk = 1'b0;
  logic                    i_rstn;
  logic                    i_start;
  logic [AW-1:0]           o_vec_addr;
  logic [2*WIDTH+OP_W-1:0] i_vec_data;
  logic [WIDTH-1:0]        i_gold_data;
  logic [WIDTH-1:0]        o_alu_a;
  logic [WIDTH-1:0]        o_alu_b;
  logic [OP_W-1:0]         o_alu_op;
  logic [WIDTH-1:0]        i_alu_result;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_pass;
  logic [CW-1:0]           o_err_count;
`ifdef ALU_BIST_FAIL_LOG_EN
  logic                    o_fail_valid;
  logic [AW-1:0]           o_fail_idx;
  logic [WIDTH-1:0]        o_fail_result;
`endif

  alu_bist #(.WIDTH(WIDTH), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .o_vec_addr   (o_vec_addr),
    .i_vec_data   (i_vec_data),
    .i_gold_data  (i_gold_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
`ifdef ALU_BIST_FAIL_LOG_EN
    .o_fail_valid (o_fail_valid),
    .o_fail_idx   (o_fail_idx),
    .o_fail_result(o_fail_result),
`endif
    .o_err_count  (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  // ALU under test: opcodes 0..4 are add, sub, and, or, xor; any other opcode passes A.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [OP_W-1:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

  // Vector ROM with a one-cycle read latency.
  logic [WIDTH-1:0] rom_a [DEPTH];
  logic [WIDTH-1:0] rom_b [DEPTH];
  logic [OP_W-1:0]  rom_op[DEPTH];
  logic [WIDTH-1:0] rom_g [DEPTH];

  always @(posedge i_clk) begin
    i_vec_data  <= {rom_a[o_vec_addr], rom_b[o_vec_addr], rom_op[o_vec_addr]};
    i_gold_data <= rom_g[o_vec_addr];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int               t0;
    int               err;
    bit               pass;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [OP_W-1:0]  last_op;
    bit               fvalid;
    int               fidx;
    logic [WIDTH-1:0] fres;
  } exp_t;

  exp_t exp_q[$];

  // Fill the ROM with random vectors; set bits of mask mark vectors whose gold is corrupted.
  task automatic load_vectors(input int mask);
    for (int i = 0; i < DEPTH; i++) begin
      rom_a[i]  = $urandom;
      rom_b[i]  = $urandom;
      rom_op[i] = OP_W'($urandom_range(0, 6));
      rom_g[i]  = alu_ref(rom_a[i], rom_b[i], rom_op[i]);
      if (mask[i]) rom_g[i] = rom_g[i] ^ ($urandom | 32'd1);
    end
  endtask

  // Work out the outcome of a whole run from the ROM contents alone.
  function automatic exp_t predict(input int t0);
    exp_t e;
    logic [WIDTH-1:0] r;
    e.t0 = t0; e.err = 0; e.fvalid = 0; e.fidx = 0; e.fres = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r = alu_ref(rom_a[i], rom_b[i], rom_op[i]);
      if (r !== rom_g[i]) begin
        if (!e.fvalid) begin
          e.fvalid = 1; e.fidx = i; e.fres = r;
        end
        e.err++;
      end
    end
    e.pass    = (e.err == 0);
    e.last_a  = rom_a[DEPTH-1];
    e.last_b  = rom_b[DEPTH-1];
    e.last_op = rom_op[DEPTH-1];
    return e;
  endfunction

  // Pulse i_start for one cycle and record the expected run outcome.
  task automatic start_run();
    @(posedge i_clk); #1;
    i_start = 1'b1;
    exp_q.push_back(predict(cyc));
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(negedge i_clk); #1;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: compare against the scoreboard on each rising edge of o_done.
  logic done_prev = 1'b0;
  exp_t mon_e;
  always @(negedge i_clk) begin
    if (o_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency",   64'(cyc - mon_e.t0), 64'(3*DEPTH+1));
        chk("err_count", 64'(o_err_count), 64'(mon_e.err));
        chk("pass",      64'(o_pass), 64'(mon_e.pass));
        chk("busy_done", 64'(o_busy), 64'd0);
        chk("alu_a",     64'(o_alu_a), 64'(mon_e.last_a));
        chk("alu_b",     64'(o_alu_b), 64'(mon_e.last_b));
        chk("alu_op",    64'(o_alu_op), 64'(mon_e.last_op));
        chk("vec_addr",  64'(o_vec_addr), 64'(DEPTH-1));
`ifdef ALU_BIST_FAIL_LOG_EN
        chk("fail_valid", 64'(o_fail_valid), 64'(mon_e.fvalid));
        chk("fail_idx",   64'(o_fail_idx), 64'(mon_e.fidx));
        chk("fail_res",   64'(o_fail_result), 64'(mon_e.fres));
`endif
      end
    end
    done_prev = o_done;
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_vec_addr"}, 64'(o_vec_addr), 64'd0);
    chk({tag, "_alu_a"},    64'(o_alu_a), 64'd0);
    chk({tag, "_alu_b"},    64'(o_alu_b), 64'd0);
    chk({tag, "_alu_op"},   64'(o_alu_op), 64'd0);
    chk({tag, "_busy"},     64'(o_busy), 64'd0);
    chk({tag, "_done"},     64'(o_done), 64'd0);
    chk({tag, "_pass"},     64'(o_pass), 64'd0);
    chk({tag, "_err"},      64'(o_err_count), 64'd0);
`ifdef ALU_BIST_FAIL_LOG_EN
    chk({tag, "_fvalid"},   64'(o_fail_valid), 64'd0);
`endif
  endtask

  initial begin
    i_rstn  = 1'b0;
    i_start = 1'b0;
    load_vectors(0);
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_state("rst");
    i_rstn = 1'b1;

    // All gold matching, first vector is ADD 5+7=12.
    rom_a[0] = 32'd5; rom_b[0] = 32'd7; rom_op[0] = 5'd0; rom_g[0] = 32'd12;
    start_run();
    wait_done();

    // Vector 2 gold corrupted.
    load_vectors(0);
    rom_g[2] = 32'hDEADBEEF;
    if (alu_ref(rom_a[2], rom_b[2], rom_op[2]) == 32'hDEADBEEF) rom_g[2] = 32'hDEADBEEE;
    start_run();
    wait_done();

    // All gold corrupted: count reaches DEPTH without overflow.
    load_vectors(4'hF);
    start_run();
    wait_done();

    // Second start while busy is ignored; completion time unchanged.
    load_vectors(4'h9);
    start_run();
    repeat (3) @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wait_done();

    // Reset mid-run clears everything immediately, then a fresh run completes.
    load_vectors(4'h2);
    start_run();
    repeat (4) @(posedge i_clk);
    #1 i_rstn = 1'b0;
    exp_q.delete();
    #1 check_reset_state("midrst");
    @(posedge i_clk); #1 i_rstn = 1'b1;
    start_run();
    wait_done();

    // Failing run, then restart from DONE with fixed gold.
    load_vectors(4'h5);
    start_run();
    wait_done();
    for (int i = 0; i < DEPTH; i++) rom_g[i] = alu_ref(rom_a[i], rom_b[i], rom_op[i]);
    start_run();
    wait_done();

    // Random runs with random corruption patterns.
    for (int r = 0; r < 6; r++) begin
      load_vectors(int'($urandom_range(0, 15)));
      start_run();
      wait_done();
    end

    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
